// File: rtl/cfs_apb_master.sv
// cfs_apb_master: APB3 requester bridging a valid/ready request channel to the bus and returning responses, with a wait-state timeout
module cfs_apb_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  expired;

    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready_d   = req_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                state_d     = SETUP;
                req_ready_d = 1'b0;
                psel_d      = 1'b1;
                paddr_d     = req_addr;
                pwrite_d    = req_write;
                pwdata_d    = req_write ? req_wdata : '0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: if (pready || expired) begin
                state_d       = RESP;
                psel_d        = 1'b0;
                penable_d     = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_slverr_d  = pready ? pslverr : 1'b1;
                rsp_timeout_d = !pready;
                rsp_rdata_d   = (pready && !pwrite_q) ? prdata : '0;
            end else begin
                cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;
endmodule
